// File: rtl/arbiter_rr.sv
// -----------------------------------------------------------------------------
// arbiter_rr
//   Round-robin arbiter that sits between four input-class FIFOs and four
//   output-destination FIFOs.
//   In each cycle it issues at most one pop to an input FIFO and, in the same
//   cycle, the matching push to the output FIFO named by bits
//   [DEST_MSB:DEST_MSB-1] of that input's head word.
//   It does not push to a destination whose almost-full flag is set.
//
// Ports
//   clk               in   rising-edge clock
//   reset_L           in   asynchronous active-low reset
//   init              in   forces INIT; clears rr pointer and word counter
//   fifo_empty        in   empty flag per input FIFO (bit i = FIFO i)
//   fifo_almost_full  in   almost-full flag per output FIFO (bit d = dest d)
//   head0..head3      in   first-word-fall-through head of input FIFO 0..3
//   arb_pop           out  one-hot pop to input FIFOs (0 = none)
//   arb_push          out  one-hot push to output FIFOs (0 = none)
//   state             out  RESET=0, INIT=1, IDLE=2, ACTIVE=3, PAUSE=4
//   idle              out  high while state == IDLE
//   words_sent        out  number of pushes issued, wraps at 256
// -----------------------------------------------------------------------------
module arbiter_rr #(
    parameter int FIFO_UNITS = 4,   // logic below is written for 4
    parameter int WORD_SIZE  = 10,
    parameter int DEST_MSB   = 9
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic [FIFO_UNITS-1:0] fifo_empty,
    input  logic [FIFO_UNITS-1:0] fifo_almost_full,
    input  logic [WORD_SIZE-1:0]  head0,
    input  logic [WORD_SIZE-1:0]  head1,
    input  logic [WORD_SIZE-1:0]  head2,
    input  logic [WORD_SIZE-1:0]  head3,
    output logic [FIFO_UNITS-1:0] arb_pop,
    output logic [FIFO_UNITS-1:0] arb_push,
    output logic [2:0]            state,
    output logic                  idle,
    output logic [7:0]            words_sent
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_PAUSE  = 3'd4;

    logic [2:0] r_state;
    logic [1:0] r_rr_ptr;
    logic [7:0] r_words_sent;

    logic [2:0] w_next_state;
    logic [1:0] w_dest [4];
    logic [3:0] w_eligible;
    logic       w_found;
    logic [1:0] w_win;
    logic       w_pop_en;
    logic       w_all_empty;
    logic       w_unused_head_bits;

    // Destination field of each head word.
    assign w_dest[0] = head0[DEST_MSB -: 2];
    assign w_dest[1] = head1[DEST_MSB -: 2];
    assign w_dest[2] = head2[DEST_MSB -: 2];
    assign w_dest[3] = head3[DEST_MSB -: 2];

    // Payload bits are carried by the FIFOs. Only the destination field is
    // used here.
    assign w_unused_head_bits = ^{head0, head1, head2, head3};

    // An input is eligible when it has data and its destination has room.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_eligible[i] = !fifo_empty[i] && !fifo_almost_full[w_dest[i]];
        end
    end

    assign w_all_empty = &fifo_empty;

    // Scan from the round-robin pointer. The first eligible input wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, so no path leaves one unassigned and no latch is inferred.
        logic [1:0] idx;
        w_found = 1'b0;
        w_win   = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = r_rr_ptr + 2'(k);
            if (!w_found && w_eligible[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    // Next-state logic. init overrides everything except RESET.
    always_comb begin
        w_next_state = r_state;
        w_pop_en     = 1'b0;
        if (r_state == ST_RESET) begin
            w_next_state = ST_INIT;
        end else if (init) begin
            // A pending grant in ACTIVE is dropped: w_pop_en stays low.
            w_next_state = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: w_next_state = ST_IDLE;
                // Entering ACTIVE takes a cycle. The first pop happens
                // in ACTIVE.
                ST_IDLE: if (!w_all_empty) w_next_state = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (w_found) begin
                        w_pop_en = 1'b1;
                    end else if (w_all_empty) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_found) begin
                        w_next_state = ST_ACTIVE;
                    end else if (w_all_empty) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_INIT;
            endcase
        end
    end

    // Mealy outputs. The pop and its push go out in the same cycle.
    assign arb_pop  = w_pop_en ? (FIFO_UNITS'(1) << w_win)         : '0;
    assign arb_push = w_pop_en ? (FIFO_UNITS'(1) << w_dest[w_win]) : '0;

    // NOTE: the asynchronous reset forces RESET at once. arb_pop and arb_push
    // decode only ACTIVE, so they drop in the same instant and do not wait
    // for a clock edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state      <= ST_RESET;
            r_rr_ptr     <= 2'd0;
            r_words_sent <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments make every register sample
            // pre-edge values, which keeps the state and counter updates
            // order-independent.
            r_state <= w_next_state;
            if (r_state == ST_INIT || w_next_state == ST_INIT) begin
                r_rr_ptr     <= 2'd0;
                r_words_sent <= 8'd0;
            end else if (w_pop_en) begin
                r_rr_ptr     <= w_win + 2'd1;
                r_words_sent <= r_words_sent + 8'd1;
            end
        end
    end

    assign state      = r_state;
    assign idle       = (r_state == ST_IDLE);
    assign words_sent = r_words_sent;

endmodule

// File: tb/tb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_arbiter_rr
//   Directed bench for arbiter_rr. A small queue model stands in for the
//   input FIFOs: arb_pop removes head words at the clock edge. Per-cycle
//   expectations of {arb_pop, arb_push, state} are queued when the stimulus
//   is set up. They are popped and compared at the falling edge of the clock.
// -----------------------------------------------------------------------------
module tb_arbiter_rr;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic [3:0] fifo_empty;
    logic [3:0] fifo_almost_full;
    logic [9:0] head0, head1, head2, head3;
    logic [3:0] arb_pop;
    logic [3:0] arb_push;
    logic [2:0] state;
    logic       idle;
    logic [7:0] words_sent;

    typedef struct packed {
        logic [3:0] pop;
        logic [3:0] push;
        logic [2:0] st;
    } exp_t;

    exp_t       sb [$];
    logic [9:0] fq [4][$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;

    arbiter_rr #(
        .FIFO_UNITS(4),
        .WORD_SIZE (10),
        .DEST_MSB  (9)
    ) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .init            (init),
        .fifo_empty      (fifo_empty),
        .fifo_almost_full(fifo_almost_full),
        .head0           (head0),
        .head1           (head1),
        .head2           (head2),
        .head3           (head3),
        .arb_pop         (arb_pop),
        .arb_push        (arb_push),
        .state           (state),
        .idle            (idle),
        .words_sent      (words_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the FIFO-side inputs from the queue model.
    task automatic refresh();
        for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
        head0 = (fq[0].size() > 0) ? fq[0][0] : 10'h0;
        head1 = (fq[1].size() > 0) ? fq[1][0] : 10'h0;
        head2 = (fq[2].size() > 0) ? fq[2][0] : 10'h0;
        head3 = (fq[3].size() > 0) ? fq[3][0] : 10'h0;
    endtask

    task automatic expect_cyc(input logic [3:0] p, input logic [3:0] q, input logic [2:0] s);
        sb.push_back('{pop: p, push: q, st: s});
    endtask

    // Compare n queued cycles. Returns one time unit after the last rising edge.
    task automatic run(input int n);
        exp_t       e;
        logic [3:0] popped;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("arb_pop c%0d", cyc),  {4'h0, arb_pop},  {4'h0, e.pop});
            check($sformatf("arb_push c%0d", cyc), {4'h0, arb_push}, {4'h0, e.push});
            check($sformatf("state c%0d", cyc),    {5'h0, state},    {5'h0, e.st});
            check($sformatf("idle c%0d", cyc),     {7'h0, idle},     {7'h0, (e.st == S_IDLE)});
            popped = arb_pop;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (popped[i] && fq[i].size() > 0) fq[i].delete(0);
            end
            refresh();
            cyc++;
        end
    endtask

    initial begin
        reset_L          = 1'b0;
        init             = 1'b0;
        fifo_almost_full = 4'b0000;
        refresh();

        // Reset, then an init pulse: states 0,1,1,2.
        expect_cyc(4'b0, 4'b0, S_RESET);
        expect_cyc(4'b0, 4'b0, S_RESET);
        run(2);
        check("words_in_reset", words_sent, 8'd0);
        reset_L = 1'b1;
        init    = 1'b1;
        expect_cyc(4'b0, 4'b0, S_RESET);
        expect_cyc(4'b0, 4'b0, S_INIT);
        run(2);
        init = 1'b0;
        expect_cyc(4'b0, 4'b0, S_INIT);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(2);
        check("words_after_init", words_sent, 8'd0);

        // Single stream: FIFO0 holds 3 words for destination 2.
        for (int k = 1; k <= 3; k++) fq[0].push_back(10'h200 + 10'(k));
        refresh();
        expect_cyc(4'b0, 4'b0, S_IDLE);
        for (int k = 0; k < 3; k++) expect_cyc(4'b0001, 4'b0100, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(6);
        check("words_single", words_sent, 8'd3);

        // An init pulse in IDLE clears the pointer and the counter.
        init = 1'b1;
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(1);
        init = 1'b0;
        expect_cyc(4'b0, 4'b0, S_INIT);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(2);
        check("words_reinit", words_sent, 8'd0);

        // Fairness: every input is non-empty. Input i targets destination i.
        fq[0].push_back(10'h001);
        fq[0].push_back(10'h002);
        fq[1].push_back(10'h101);
        fq[2].push_back(10'h201);
        fq[3].push_back(10'h301);
        refresh();
        expect_cyc(4'b0, 4'b0, S_IDLE);
        expect_cyc(4'b0001, 4'b0001, S_ACTIVE);
        expect_cyc(4'b0010, 4'b0010, S_ACTIVE);
        expect_cyc(4'b0100, 4'b0100, S_ACTIVE);
        expect_cyc(4'b1000, 4'b1000, S_ACTIVE);
        expect_cyc(4'b0001, 4'b0001, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(8);
        check("words_fair", words_sent, 8'd5);

        // Backpressure: FIFO1 and FIFO2 both target the full destination 3.
        fq[1].push_back(10'h302);
        fq[2].push_back(10'h303);
        fifo_almost_full = 4'b1000;
        refresh();
        expect_cyc(4'b0, 4'b0, S_IDLE);
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_PAUSE);
        run(3);
        fifo_almost_full = 4'b0000;
        expect_cyc(4'b0, 4'b0, S_PAUSE);
        expect_cyc(4'b0010, 4'b1000, S_ACTIVE);
        expect_cyc(4'b0100, 4'b1000, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(5);
        check("words_backpressure", words_sent, 8'd7);

        // Partial block: FIFO0 targets the full destination 1 and FIFO3
        // targets the free destination 0.
        fq[0].push_back(10'h111);
        fq[0].push_back(10'h112);
        fq[3].push_back(10'h011);
        fq[3].push_back(10'h012);
        fifo_almost_full = 4'b0010;
        refresh();
        expect_cyc(4'b0, 4'b0, S_IDLE);
        expect_cyc(4'b1000, 4'b0001, S_ACTIVE);
        expect_cyc(4'b1000, 4'b0001, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_PAUSE);
        run(5);
        fifo_almost_full = 4'b0000;
        expect_cyc(4'b0, 4'b0, S_PAUSE);
        expect_cyc(4'b0001, 4'b0010, S_ACTIVE);
        expect_cyc(4'b0001, 4'b0010, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(5);
        check("words_partial", words_sent, 8'd11);

        // init in ACTIVE suppresses that cycle's pop. Then the pointer
        // restarts at 0.
        for (int k = 1; k <= 4; k++) fq[2].push_back(10'h100 + 10'(k));
        refresh();
        expect_cyc(4'b0, 4'b0, S_IDLE);
        expect_cyc(4'b0100, 4'b0010, S_ACTIVE);
        run(2);
        init = 1'b1;
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        run(1);
        init = 1'b0;
        expect_cyc(4'b0, 4'b0, S_INIT);
        run(1);
        check("words_init_active", words_sent, 8'd0);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        expect_cyc(4'b0100, 4'b0010, S_ACTIVE);
        run(2);

        // Abort: reset_L drops in the middle of an ACTIVE cycle.
        #2;
        check("pop_before_abort", {4'h0, arb_pop}, 8'h04);
        reset_L = 1'b0;
        #1;
        check("abort_pop",   {4'h0, arb_pop},  8'h00);
        check("abort_push",  {4'h0, arb_push}, 8'h00);
        check("abort_state", {5'h0, state},    8'h00);
        check("abort_idle",  {7'h0, idle},     8'h00);
        check("abort_words", words_sent,       8'h00);
        for (int i = 0; i < 4; i++) fq[i].delete();
        refresh();
        expect_cyc(4'b0, 4'b0, S_RESET);
        run(1);

        // Wrap: 256 pushes take words_sent back to 0.
        reset_L = 1'b1;
        for (int k = 0; k < 256; k++) fq[0].push_back(10'(k));
        refresh();
        expect_cyc(4'b0, 4'b0, S_RESET);
        expect_cyc(4'b0, 4'b0, S_INIT);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        for (int k = 0; k < 256; k++) expect_cyc(4'b0001, 4'b0001, S_ACTIVE);
        run(3 + 255);
        check("words_255", words_sent, 8'd255);
        run(1);
        check("words_wrap", words_sent, 8'd0);
        expect_cyc(4'b0, 4'b0, S_ACTIVE);
        expect_cyc(4'b0, 4'b0, S_IDLE);
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Round-robin arbiter between the four input-class FIFOs and the four output-destination FIFOs.
- Each cycle it issues at most one pop to an input FIFO and the matching push to an output FIFO.
- The destination comes from bits [9:8] of the head word of the selected input FIFO.
- It drives the arb_pop and arb_push one-hot buses of the mux/demux stage directly downstream, throttled by output almost-full flags.

Parameters:
FIFO_UNITS, 4, number of input FIFOs and number of output FIFOs (logic written for 4)
WORD_SIZE, 10, FIFO word width
DEST_MSB, 9, MSB of the 2-bit destination field; field is [DEST_MSB:DEST_MSB-1]

Ports:
clk  input  1  single clock, rising edge
reset_L  input  1  asynchronous, active-low reset
init  input  1  forces INIT state, clears counter
fifo_empty  input  FIFO_UNITS  empty flags of the input FIFOs, bit i = FIFO i
fifo_almost_full  input  FIFO_UNITS  almost-full flags of the output FIFOs, bit d = destination d
head0..head3  input  WORD_SIZE each  first-word-fall-through head of input FIFO 0..3
arb_pop  output  FIFO_UNITS  one-hot pop to input FIFOs (all zero = none)
arb_push  output  FIFO_UNITS  one-hot push to output FIFOs
state  output  3  current FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, PAUSE=4
idle  output  1  1 when state==IDLE
words_sent  output  8  count of pushes issued

Behaviour:
- Reset:
  - reset_L=0 asynchronously sets state=RESET, rr_ptr=0 and words_sent=0.
  - While in reset, arb_pop=0, arb_push=0 and idle=0.
  - Reset asserted mid-transfer aborts with no further pop or push.
- Registered vs combinational:
  - state, rr_ptr (2 bits) and words_sent are registered.
  - arb_pop and arb_push are combinational (Mealy) from registered state and current inputs.
  - Both are nonzero only in ACTIVE.
  - Zero latency: a pop and its push are issued in the same cycle; the FIFOs act on that clock edge.
- Eligibility: input i is eligible when fifo_empty[i]==0 and fifo_almost_full[d_i]==0, where d_i = head_i[DEST_MSB:DEST_MSB-1].
- Selection:
  - Scan i = rr_ptr, rr_ptr+1, ... mod 4; the first eligible i wins.
  - Set arb_pop[i]=1 and arb_push[d_i]=1.
  - At the edge: rr_ptr <= (i+1) mod 4 and words_sent <= words_sent+1. words_sent wraps 255->0.
  - No winner: rr_ptr is held.
- Transitions (priority top-down):
  - Any state except RESET, init=1 -> INIT.
  - RESET -> INIT on the first clock after reset_L rises.
  - INIT: words_sent held at 0, rr_ptr=0. Exits to IDLE when init=0.
  - IDLE:
    - -> ACTIVE if any fifo_empty bit is 0.
    - No pop in the transition cycle, so entering ACTIVE costs 1 cycle.
  - ACTIVE:
    - Stays ACTIVE while a winner exists.
    - All input FIFOs empty -> IDLE.
    - Some FIFO non-empty but none eligible (all blocked by almost_full) -> PAUSE; no pop that cycle.
  - PAUSE:
    - No pops or pushes.
    - -> ACTIVE when any input becomes eligible.
    - -> IDLE when all inputs are empty.
- Simultaneous events:
  - init=1 in ACTIVE suppresses the pop in that cycle.
  - Multiple eligible inputs: only the round-robin winner is served.
  - Two inputs targeting the same destination: served in rotating order, one per cycle.
- The arbiter never pops an empty FIFO.
- The arbiter never pushes to a destination whose almost_full is 1 in that cycle. The almost-full threshold guarantees room for the in-flight word.
- idle = (state==IDLE).

Test Plan:
- Reset then init pulse: reset_L 0->1, init=1 for 2 cycles then 0 -> state 0,1,1,2; outputs 0, words_sent=0.
- Single stream: FIFO0 holds 3 words with head[9:8]=2'b10, others empty -> IDLE->ACTIVE. arb_pop=0001 and arb_push=0100 for 3 cycles, then IDLE; words_sent=3.
- Fairness: all 4 FIFOs non-empty, dests 0,1,2,3, no almost_full -> arb_pop sequence 0001,0010,0100,1000,0001; pushes match dests.
- Backpressure: FIFO1 and FIFO2 both target dest 3, fifo_almost_full=1000 -> PAUSE, no pops. Deassert -> ACTIVE, pop 0010 then 0100.
- Partial block: FIFO0 targets the blocked dest 1, FIFO3 targets dest 0 -> only FIFO3 is served, arb_push=0001; state stays ACTIVE.
- Abort and wrap:
  - Assert reset_L=0 mid-ACTIVE -> outputs 0 immediately and state=0.
  - Separately, 256 pushes -> words_sent wraps to 0.
